// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 16x-oversampling UART receiver; optional parity via `define UART_RX_PARITY_EN
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Index of the final data bit, compared against the bit counter.
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    // START resamples on the 7th tick after the falling edge was seen (mid start bit).
    localparam logic [3:0] MID_START = 4'd6;
    // DATA/PARITY/STOP sample once the 4-bit counter reaches its top and wraps.
    localparam logic [3:0] CNT_TOP   = 4'd15;

    state_t               state_q,      state_d;
    logic                 rx_meta_q,    rx_meta_d;
    logic                 rx_s_q,       rx_s_d;
    logic [3:0]           sample_cnt_q, sample_cnt_d;
    logic [3:0]           bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [7:0]           rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 busy_q,       busy_d;
`ifdef UART_RX_PARITY_EN
    localparam logic      PAR_INV = (PARITY_ODD != 0);
    logic                 par_bad_q,    par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // Next-state logic: synchroniser always shifts, everything else advances only on baud_tick.
    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d      = S_START;
                        sample_cnt_d = '0;
                    end
                end
                S_START: begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == MID_START) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        // A high level at mid start bit was only a glitch.
                        state_d      = rx_s_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    // Counter wraps 15 -> 0 on the sampling tick, lining up the next bit.
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == CNT_TOP) begin
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == CNT_TOP) begin
                        // Held until the stop bit so both strobes land on the same clk.
                        par_bad_d = ((^shift_q) ^ PAR_INV) != rx_s_q;
                        state_d   = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == CNT_TOP) begin
                        rx_data_d                  = '0;
                        rx_data_d[DATA_BITS-1:0]   = shift_q;
                        rx_valid_d                 = rx_s_q;
                        frame_err_d                = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_d               = par_bad_q;
                        par_bad_d                  = 1'b0;
`endif
                        // Leaving at mid stop bit lets a directly following start edge be caught.
                        state_d                    = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
